// File: rtl/gesture_key_conditioner.sv
// rtl/gesture_key_conditioner.sv - synchronise, debounce and edge-detect two gesture buttons
module gesture_key_conditioner #(
    parameter logic [31:0] DEBOUNCE_CYCLES   = 32'd2000000,
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd200000000
) (
    input  logic clk,
    input  logic reset,
    input  logic left_btn_raw,
    input  logic right_btn_raw,
    output logic left_key,
    output logic right_key,
    output logic left_held,
    output logic right_held,
    output logic left_long,
    output logic right_long,
    output logic conflict
);

    // Channel index 0 is left, 1 is right.
    logic [1:0]  raw;
    logic [1:0]  s1_q;
    logic [1:0]  s2_q;
    logic [1:0]  stable_q;
    logic [1:0]  stable_d;
    logic [1:0]  fired_q;
    logic [1:0]  fired_d;
    logic [1:0]  press;
    logic [1:0]  key_q;
    logic [1:0]  key_d;
    logic [1:0]  long_q;
    logic [1:0]  long_d;
    logic        conflict_q;
    logic        conflict_d;
    logic [31:0] dcnt_q [2];
    logic [31:0] dcnt_d [2];
    logic [31:0] hcnt_q [2];
    logic [31:0] hcnt_d [2];

    assign raw = {right_btn_raw, left_btn_raw};

    // Per-channel debounce, hold counting and press detection.
    always_comb begin
        stable_d = stable_q;
        fired_d  = fired_q;
        long_d   = 2'b00;
        press    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = dcnt_q[i];
            hcnt_d[i] = hcnt_q[i];

            // Any disagreement must persist DEBOUNCE_CYCLES edges; a bounce restarts it.
            if (s2_q[i] == stable_q[i]) begin
                dcnt_d[i] = 32'd0;
            end else if (dcnt_q[i] == DEBOUNCE_CYCLES - 32'd1) begin
                stable_d[i] = s2_q[i];
                dcnt_d[i]   = 32'd0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + 32'd1;
            end

            press[i] = stable_d[i] & ~stable_q[i];

            // Hold counter runs only while the debounced level stays high and saturates.
            if (!stable_d[i]) begin
                hcnt_d[i]  = 32'd0;
                fired_d[i] = 1'b0;
            end else if (stable_q[i] && (hcnt_q[i] < LONG_PRESS_CYCLES)) begin
                hcnt_d[i] = hcnt_q[i] + 32'd1;
                if ((hcnt_q[i] == LONG_PRESS_CYCLES - 32'd1) && !fired_q[i]) begin
                    long_d[i]  = 1'b1;
                    fired_d[i] = 1'b1;
                end
            end
        end

        // Simultaneous presses are ambiguous: suppress both keys and flag it instead.
        conflict_d = &press;
        key_d      = conflict_d ? 2'b00 : press;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= 2'b00;
            s2_q       <= 2'b00;
            stable_q   <= 2'b00;
            fired_q    <= 2'b00;
            key_q      <= 2'b00;
            long_q     <= 2'b00;
            conflict_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= 32'd0;
                hcnt_q[i] <= 32'd0;
            end
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            stable_q   <= stable_d;
            fired_q    <= fired_d;
            key_q      <= key_d;
            long_q     <= long_d;
            conflict_q <= conflict_d;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign left_key   = key_q[0];
    assign right_key  = key_q[1];
    assign left_held  = stable_q[0];
    assign right_held = stable_q[1];
    assign left_long  = long_q[0];
    assign right_long = long_q[1];
    assign conflict   = conflict_q;

endmodule

// File: doc/gesture_key_conditioner.md
# gesture_key_conditioner

Conditions the two raw gesture buttons into the clean, one-cycle key events consumed by the gesture power controller's `left_key` / `right_key` inputs. Each channel is synchronised, debounced, and edge-detected. The block also reports debounced hold levels and long-press events, and suppresses same-cycle double presses so the power controller never sees an ambiguous gesture start. It sits between the board push-buttons and the power/gesture FSMs, all on the 100 MHz system clock.

## Interface

- `DEBOUNCE_CYCLES`, 32'd2000000: consecutive cycles a changed input must persist before it is accepted (20 ms); legal range ≥ 1.
- `LONG_PRESS_CYCLES`, 32'd200000000: cycles a debounced press must last before a long-press event fires (2 s); legal range ≥ 1.

- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset; one clock; all state cleared while low.
- `left_btn_raw`  input  1  raw left button, asynchronous to `clk`, bouncy.
- `right_btn_raw`  input  1  raw right button, asynchronous to `clk`, bouncy.
- `left_key`  output  1  one-cycle pulse on an accepted left press.
- `right_key`  output  1  one-cycle pulse on an accepted right press.
- `left_held`  output  1  debounced left level.
- `right_held`  output  1  debounced right level.
- `left_long`  output  1  one-cycle pulse when the left press reaches `LONG_PRESS_CYCLES`.
- `right_long`  output  1  one-cycle pulse when the right press reaches `LONG_PRESS_CYCLES`.
- `conflict`  output  1  one-cycle pulse when both presses are accepted on the same edge.

## Operation

- **Per channel, identical logic:**
  - 2-flop synchroniser `s1` → `s2`.
  - Debounced register `stable`.
  - 32-bit debounce counter `dcnt`.
  - 32-bit hold counter `hcnt`.
  - Long-press-fired flag.
- **Debounce, evaluated each edge:**
  - If `s2 == stable`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `dcnt <= 0`.
  - Else: `dcnt <= dcnt + 1`.
  - Any bounce back to `stable` restarts the count from 0.
- `*_held` is `stable`.
- **Press event:** a candidate press is the edge on which `stable` goes 0→1. Releases produce no key pulse.
- **Conflict arbitration:**
  - Both channels have a candidate press on the same edge: `left_key = right_key = 0` and `conflict = 1` for that cycle. Both `*_held` still rise normally.
  - Only one channel has a candidate press: its `*_key` pulses, even if the other channel is already held.
- **Long press:**
  - While `stable == 1`, `hcnt` increments and saturates at `LONG_PRESS_CYCLES`.
  - `*_long` pulses on the edge where `hcnt` becomes `LONG_PRESS_CYCLES`; it fires at most once per press.
  - On `stable` 1→0: `hcnt <= 0` and the fired flag is cleared.
  - A conflicted press still counts toward long press.
- **Reset (`reset` low, asynchronously):**
  - All outputs go to 0.
  - `s1`, `s2`, `stable`, `dcnt`, `hcnt` and the fired flags are cleared.
  - A button held through reset release is treated as a new press: one `*_key` pulse after the full debounce latency.

## Timing

- **Press latency:** raw goes high before clock edge N (first edge sampling 1) and stays clean. Then `*_held` and `*_key` are both high after edge `N + DEBOUNCE_CYCLES + 1`, and `*_key` drops after the next edge.
- **Release latency:** identical count; `*_held` falls after edge `N + DEBOUNCE_CYCLES + 1`.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles, as seen at `s2`, never changes `*_held`.
- **Long-press timing:** `*_long` is high exactly `LONG_PRESS_CYCLES` edges after the edge on which `*_held` rose.
- **Output registration:** all outputs are registered; there are no combinational paths from the raw inputs.
- **Counter range:** counters never wrap; `DEBOUNCE_CYCLES - 1` and `LONG_PRESS_CYCLES` both fit in 32 bits.

## Test plan

Benches override `DEBOUNCE_CYCLES=4` and `LONG_PRESS_CYCLES=10`.

1. **Clean left press:** `left_btn_raw` high before edge 10 and held → `left_held` high after edge 15; `left_key` high for exactly the cycle after edge 15; `right_key` and `conflict` stay 0.
2. **Bounce rejection:** `left_btn_raw` toggles 1,0,1,0 on successive edges, then steady 1 from edge 20 → no activity before edge 25; single `left_key` pulse after edge 25.
3. **Simultaneous press:** both raw inputs high before edge 10 → after edge 15, both `*_held` are 1, `conflict` = 1 for one cycle, `left_key = right_key = 0`.
4. **Sequential presses:** right press with raw high before edge 10 (`right_key` after edge 15), then left press with raw high before edge 30 → `left_key` after edge 35 while `right_held` = 1; `conflict` never asserts.
5. **Long press:** left held from edge 10 → `left_long` one pulse after edge 25 and no repeat through edge 60; release, then press again → a second `left_long` fires 10 edges after the new `left_held` rise.
6. **Reset mid-debounce:** raw left high before edge 10; `reset` low from edge 12 to edge 14 → all outputs 0 during reset; after release, `left_key` pulses after edge `R + 5`, where R is the first edge with `reset` high.
